icap_load_scheduler: RTL and testbench

//  Shares one ICAP flash loader (SPI read -> ICAP byte stream) among N_REQ requesters.

---
 rtl/icap_load_scheduler.sv | 267 ++++++++++++++++++++++++++
 tb/tb_icap_load_scheduler.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/icap_load_scheduler.sv
// ---------------------------------------------------------------------------
// icap_load_scheduler
//
// Shares one ICAP flash loader among N_REQ requesters. Each requester names a
// bitstream slot; a slot table holds the flash address and byte length for
// every slot. Requests are served one at a time in round-robin order. Each
// load ends in a done pulse or an err pulse for the requester that owned it.
//
// Ports
//   clk_i          system clock, all logic on the rising edge
//   rst_ni         synchronous reset, active low
//   req_i          level request per requester, held until done/err
//   req_slot_i     slot per requester, [i*SLOT_W +: SLOT_W]
//   grant_o        one-hot, requester currently being served
//   done_o         1-cycle pulse, load finished OK
//   err_o          1-cycle pulse, zero-length slot or watchdog timeout
//   busy_o         high whenever the scheduler is not idle
//   cfg_we_i       slot table write strobe
//   cfg_slot_i     slot index to write
//   cfg_addr_i     flash byte address for the slot
//   cfg_len_i      byte count for the slot (0 marks the slot invalid)
//   ld_trigger_o   1-cycle start pulse to the loader
//   ld_addr_o      address to the loader, stable from trigger to done
//   ld_len_o       length to the loader, stable from trigger to done
//   ld_running_i   loader running flag
// ---------------------------------------------------------------------------
module icap_load_scheduler #(
    parameter int N_REQ       = 4,
    parameter int SLOT_W      = 3,
    parameter int TIMEOUT_W   = 26,
    parameter int TIMEOUT_CYC = 2 ** 25
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [N_REQ-1:0]         req_i,
    input  logic [N_REQ*SLOT_W-1:0]  req_slot_i,
    output logic [N_REQ-1:0]         grant_o,
    output logic [N_REQ-1:0]         done_o,
    output logic [N_REQ-1:0]         err_o,
    output logic                     busy_o,
    input  logic                     cfg_we_i,
    input  logic [SLOT_W-1:0]        cfg_slot_i,
    input  logic [23:0]              cfg_addr_i,
    input  logic [23:0]              cfg_len_i,
    output logic                     ld_trigger_o,
    output logic [23:0]              ld_addr_o,
    output logic [23:0]              ld_len_o,
    input  logic                     ld_running_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DEPTH = 2 ** SLOT_W;
    // The watchdog holds "cycles since trigger"; the error is registered on
    // the cycle before the limit so err appears exactly TIMEOUT_CYC cycles
    // after the trigger pulse.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_START    = 3'd1,
        S_WAIT_RUN = 3'd2,
        S_BUSY     = 3'd3,
        S_DRAIN    = 3'd4
    } state_e;

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
        logic [PTR_W-1:0] nxt;
        if (idx == PTR_W'(N_REQ - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = idx + PTR_W'(1);
        end
        return nxt;
    endfunction

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       rr_q, rr_d;
    logic [PTR_W-1:0]       g_q, g_d;
    logic [N_REQ-1:0]       grant_q, grant_d;
    logic [N_REQ-1:0]       done_q, done_d;
    logic [N_REQ-1:0]       err_q, err_d;
    logic                   trig_q, trig_d;
    logic                   busy_q, busy_d;
    logic [23:0]            addr_q, addr_d;
    logic [23:0]            len_q, len_d;
    logic [TIMEOUT_W-1:0]   wd_q, wd_d;

    logic [23:0]            tbl_addr_q [DEPTH];
    logic [23:0]            tbl_len_q  [DEPTH];

    logic [SLOT_W-1:0]      slot_arr_s [N_REQ];
    logic [N_REQ-1:0]       req_rot_s;
    logic                   pick_found_s;
    logic [PTR_W-1:0]       pick_off_s;
    logic [PTR_W:0]         pick_sum_s;
    logic [PTR_W-1:0]       win_s;
    logic [SLOT_W-1:0]      win_slot_s;

    // Unpack the flat per-requester slot bus.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            slot_arr_s[i] = req_slot_i[i*SLOT_W +: SLOT_W];
        end
    end

    // Rotate requests so bit 0 is the requester at rr_q, then take the lowest set bit.
    assign req_rot_s = N_REQ'({req_i, req_i} >> rr_q);

    // Lowest-set-bit search over the rotated request vector.
    always_comb begin
        pick_found_s = |req_rot_s;
        pick_off_s   = {PTR_W{1'b0}};
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot_s[i]) begin
                pick_off_s = PTR_W'(i);
            end else begin
                pick_off_s = pick_off_s;
            end
        end
    end

    // Undo the rotation: winner = (rr_q + offset) mod N_REQ.
    assign pick_sum_s = {1'b0, rr_q} + {1'b0, pick_off_s};
    assign win_s      = (pick_sum_s >= (PTR_W+1)'(N_REQ)) ?
                        PTR_W'(pick_sum_s - (PTR_W+1)'(N_REQ)) : pick_sum_s[PTR_W-1:0];
    assign win_slot_s = slot_arr_s[win_s];

    // Slot table lengths: cleared by reset so every slot starts invalid.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_len_q[i] <= 24'd0;
            end
        end else if (cfg_we_i) begin
            tbl_len_q[cfg_slot_i] <= cfg_len_i;
        end
    end

    // Slot table addresses: no reset, a slot is only usable once its length is written.
    always_ff @(posedge clk_i) begin
        if (cfg_we_i) begin
            tbl_addr_q[cfg_slot_i] <= cfg_addr_i;
        end
    end

    // Next-state and registered-output logic of the scheduler FSM.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        grant_d = grant_q;
        done_d  = {N_REQ{1'b0}};
        err_d   = {N_REQ{1'b0}};
        trig_d  = 1'b0;
        addr_d  = addr_q;
        len_d   = len_q;
        wd_d    = wd_q;
        case (state_q)
            S_IDLE: begin
                // The table is read from registers, so a same-cycle cfg write
                // only lands after this lookup.
                if (pick_found_s && !ld_running_i) begin
                    g_d    = win_s;
                    addr_d = tbl_addr_q[win_slot_s];
                    len_d  = tbl_len_q[win_slot_s];
                    if (tbl_len_q[win_slot_s] == 24'd0) begin
                        err_d = onehot(win_s);
                        rr_d  = next_ptr(win_s);
                    end else begin
                        grant_d = onehot(win_s);
                        trig_d  = 1'b1;
                        state_d = S_START;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                // Trigger is on the outputs this cycle; next cycle is 1 after it.
                wd_d    = WD_ONE;
                state_d = S_WAIT_RUN;
            end
            S_WAIT_RUN: begin
                if (wd_q == WD_LAST) begin
                    err_d   = grant_q;
                    state_d = S_DRAIN;
                end else if (ld_running_i) begin
                    wd_d    = wd_q + WD_ONE;
                    state_d = S_BUSY;
                end else begin
                    wd_d    = wd_q + WD_ONE;
                end
            end
            S_BUSY: begin
                if (!ld_running_i) begin
                    done_d  = grant_q;
                    grant_d = {N_REQ{1'b0}};
                    rr_d    = next_ptr(g_q);
                    state_d = S_IDLE;
                end else if (wd_q == WD_LAST) begin
                    err_d   = grant_q;
                    state_d = S_DRAIN;
                end else begin
                    wd_d    = wd_q + WD_ONE;
                end
            end
            S_DRAIN: begin
                // The loader cannot be aborted; keep ownership until it stops.
                if (!ld_running_i) begin
                    grant_d = {N_REQ{1'b0}};
                    rr_d    = next_ptr(g_q);
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                grant_d = {N_REQ{1'b0}};
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            rr_q    <= {PTR_W{1'b0}};
            g_q     <= {PTR_W{1'b0}};
            grant_q <= {N_REQ{1'b0}};
            done_q  <= {N_REQ{1'b0}};
            err_q   <= {N_REQ{1'b0}};
            trig_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= 24'd0;
            len_q   <= 24'd0;
            wd_q    <= {TIMEOUT_W{1'b0}};
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            err_q   <= err_d;
            trig_q  <= trig_d;
            busy_q  <= busy_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wd_q    <= wd_d;
        end
    end

    assign grant_o      = grant_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign ld_trigger_o = trig_q;
    assign ld_addr_o    = addr_q;
    assign ld_len_o     = len_q;

endmodule

// File: tb/tb_icap_load_scheduler.sv
// Testbench for icap_load_scheduler (N_REQ=4, SLOT_W=3, TIMEOUT_CYC=100).
module tb_icap_load_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_r;
    logic [2:0]  slot_r [4];
    logic [11:0] req_slot;
    logic [3:0]  grant, done, err;
    logic        busy, cfg_we, trig, ld_running;
    logic [2:0]  cfg_slot;
    logic [23:0] cfg_addr, cfg_len, ld_addr, ld_len;

    int checks = 0;
    int errors = 0;

    // Reference model state: round-robin pointer and slot table.
    int          m_rr;
    logic [23:0] m_addr [8];
    logic [23:0] m_len  [8];

    typedef struct {
        logic [2:0]  cslot;
        logic [23:0] caddr;
        logic [23:0] clen;
        int          ridx;
        logic [2:0]  rslot;
        logic [23:0] eaddr;
        logic [23:0] elen;
    } vec_t;

    vec_t vecs [6];
    int   rr_order [5];

    always #5 clk = ~clk;

    assign req_slot = {slot_r[3], slot_r[2], slot_r[1], slot_r[0]};

    icap_load_scheduler #(
        .N_REQ(4), .SLOT_W(3), .TIMEOUT_W(26), .TIMEOUT_CYC(100)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_r), .req_slot_i(req_slot),
        .grant_o(grant), .done_o(done), .err_o(err), .busy_o(busy),
        .cfg_we_i(cfg_we), .cfg_slot_i(cfg_slot), .cfg_addr_i(cfg_addr), .cfg_len_i(cfg_len),
        .ld_trigger_o(trig), .ld_addr_o(ld_addr), .ld_len_o(ld_len), .ld_running_i(ld_running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_rr = 0;
        for (int i = 0; i < 8; i++) m_len[i] = 24'd0;
    endtask

    task automatic set_cfg(input logic [2:0] s, input logic [23:0] a, input logic [23:0] l);
        cfg_we   = 1'b1;
        cfg_slot = s;
        cfg_addr = a;
        cfg_len  = l;
        m_addr[s] = a;
        m_len[s]  = l;
    endtask

    task automatic cfg_write(input logic [2:0] s, input logic [23:0] a, input logic [23:0] l);
        set_cfg(s, a, l);
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic request(input int r, input logic [2:0] s);
        req_r[r]  = 1'b1;
        slot_r[r] = s;
    endtask

    task automatic finish_txn(input int g);
        req_r[g] = 1'b0;
        m_rr = (g + 1) % 4;
    endtask

    function automatic int model_pick(input logic [3:0] reqs);
        for (int i = 0; i < 4; i++) begin
            if (reqs[(m_rr + i) % 4]) return (m_rr + i) % 4;
        end
        return -1;
    endfunction

    // Checks taken on the cycle right after the requester was sampled in IDLE.
    task automatic expect_arb(input int g, input logic [23:0] ea, input logic [23:0] el);
        logic [3:0] oh;
        oh = 4'(1 << g);
        chk("arb_ld_len", 32'(ld_len), 32'(el));
        chk("arb_done", 32'(done), 32'd0);
        if (el == 24'd0) begin
            chk("zero_len_err", 32'(err), 32'(oh));
            chk("zero_len_trigger", 32'(trig), 32'd0);
            chk("zero_len_grant", 32'(grant), 32'd0);
            chk("zero_len_busy", 32'(busy), 32'd0);
        end else begin
            chk("arb_ld_addr", 32'(ld_addr), 32'(ea));
            chk("arb_trigger", 32'(trig), 32'd1);
            chk("arb_grant", 32'(grant), 32'(oh));
            chk("arb_busy", 32'(busy), 32'd1);
            chk("arb_err", 32'(err), 32'd0);
        end
    endtask

    task automatic hold_checks(input logic [3:0] oh, input logic [23:0] ea, input logic [23:0] el);
        chk("hold_grant", 32'(grant), 32'(oh));
        chk("hold_done", 32'(done), 32'd0);
        chk("hold_err", 32'(err), 32'd0);
        chk("hold_trigger", 32'(trig), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_ld_addr", 32'(ld_addr), 32'(ea));
        chk("hold_ld_len", 32'(ld_len), 32'(el));
    endtask

    // Loader model: idle d1 cycles after the trigger, run d2 cycles, then stop.
    task automatic run_loader(input int g, input int d1, input int d2, input bit drop,
                              input logic [23:0] ea, input logic [23:0] el);
        logic [3:0] oh;
        oh = 4'(1 << g);
        for (int i = 0; i < d1; i++) begin
            tick();
            hold_checks(oh, ea, el);
        end
        ld_running = 1'b1;
        for (int i = 0; i < d2; i++) begin
            if (drop && i == 0) req_r[g] = 1'b0;
            tick();
            hold_checks(oh, ea, el);
        end
        ld_running = 1'b0;
        tick();
        chk("done_pulse", 32'(done), 32'(oh));
        chk("done_grant_clear", 32'(grant), 32'd0);
        chk("done_err", 32'(err), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_trigger", 32'(trig), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1, "global timeout");
    end

    initial begin
        int          g;
        logic [23:0] ea, el, rl;
        rst_n = 1'b0;
        req_r = 4'd0;
        for (int i = 0; i < 4; i++) slot_r[i] = 3'd0;
        cfg_we = 1'b0; cfg_slot = 3'd0; cfg_addr = 24'd0; cfg_len = 24'd0;
        ld_running = 1'b0;
        for (int i = 0; i < 8; i++) m_addr[i] = 24'd0;

        vecs[0] = '{3'd2, 24'h040000, 24'h000100, 1, 3'd2, 24'h040000, 24'h000100};
        vecs[1] = '{3'd0, 24'h000000, 24'h000001, 0, 3'd0, 24'h000000, 24'h000001};
        vecs[2] = '{3'd7, 24'hFFFFFF, 24'hFFFFFF, 3, 3'd7, 24'hFFFFFF, 24'hFFFFFF};
        vecs[3] = '{3'd4, 24'h123456, 24'h000000, 2, 3'd4, 24'h123456, 24'h000000};
        vecs[4] = '{3'd2, 24'h0ABCDE, 24'h000010, 0, 3'd2, 24'h0ABCDE, 24'h000010};
        vecs[5] = '{3'd1, 24'h111111, 24'h000020, 3, 3'd7, 24'hFFFFFF, 24'hFFFFFF};
        rr_order = '{0, 1, 2, 3, 0};

        // Reset state
        apply_reset();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trigger", 32'(trig), 32'd0);
        chk("rst_ld_addr", 32'(ld_addr), 32'd0);
        chk("rst_ld_len", 32'(ld_len), 32'd0);

        // Never-written slot 5 from requester 3: error only, no trigger
        request(3, 3'd5);
        tick();
        expect_arb(3, 24'd0, 24'd0);
        finish_txn(3);
        tick();
        chk("unwritten_err_once", 32'(err), 32'd0);
        chk("unwritten_busy", 32'(busy), 32'd0);
        chk("unwritten_trigger", 32'(trig), 32'd0);

        // Table-driven single-requester vectors
        for (int k = 0; k < 6; k++) begin
            cfg_write(vecs[k].cslot, vecs[k].caddr, vecs[k].clen);
            request(vecs[k].ridx, vecs[k].rslot);
            tick();
            expect_arb(vecs[k].ridx, vecs[k].eaddr, vecs[k].elen);
            if (vecs[k].elen != 24'd0) begin
                run_loader(vecs[k].ridx, k % 3, 3, 1'b0, vecs[k].eaddr, vecs[k].elen);
            end
            finish_txn(vecs[k].ridx);
        end

        // Rewrite of the in-flight slot affects only the next grant
        request(2, 3'd2);
        tick();
        expect_arb(2, 24'h0ABCDE, 24'h000010);
        cfg_write(3'd2, 24'h0DEAD0, 24'h000030);
        chk("inflight_ld_addr", 32'(ld_addr), 32'h0ABCDE);
        chk("inflight_ld_len", 32'(ld_len), 32'h000010);
        run_loader(2, 1, 4, 1'b0, 24'h0ABCDE, 24'h000010);
        finish_txn(2);
        request(1, 3'd2);
        tick();
        expect_arb(1, 24'h0DEAD0, 24'h000030);
        run_loader(1, 0, 3, 1'b0, 24'h0DEAD0, 24'h000030);
        finish_txn(1);

        // Watchdog: loader never stops, err at trigger+100, grant held, no done
        request(1, 3'd7);
        tick();
        expect_arb(1, 24'hFFFFFF, 24'hFFFFFF);
        ld_running = 1'b1;
        for (int t = 1; t <= 100; t++) begin
            tick();
            chk("wd_err", 32'(err), (t == 100) ? 32'h2 : 32'h0);
            chk("wd_grant", 32'(grant), 32'h2);
            chk("wd_done", 32'(done), 32'd0);
        end
        req_r[1] = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("drain_grant", 32'(grant), 32'h2);
            chk("drain_busy", 32'(busy), 32'd1);
            chk("drain_err", 32'(err), 32'd0);
            chk("drain_done", 32'(done), 32'd0);
        end
        ld_running = 1'b0;
        tick();
        chk("drain_end_grant", 32'(grant), 32'd0);
        chk("drain_end_done", 32'(done), 32'd0);
        chk("drain_end_busy", 32'(busy), 32'd0);
        finish_txn(1);

        // Reset during a running load
        request(0, 3'd2);
        tick();
        expect_arb(0, 24'h0DEAD0, 24'h000030);
        ld_running = 1'b1;
        for (int t = 0; t < 3; t++) tick();
        apply_reset();
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ld_addr", 32'(ld_addr), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        cfg_write(3'd2, 24'h0BEEF0, 24'h000040);
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("midrst_no_grant", 32'(grant), 32'd0);
            chk("midrst_no_trigger", 32'(trig), 32'd0);
            chk("midrst_no_err", 32'(err), 32'd0);
        end
        ld_running = 1'b0;
        tick();
        expect_arb(0, 24'h0BEEF0, 24'h000040);
        run_loader(0, 1, 2, 1'b0, 24'h0BEEF0, 24'h000040);
        finish_txn(0);

        // All four requesters held: grants 0,1,2,3,0 from a fresh pointer
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            cfg_write(3'(i), 24'((i + 1) << 20), 24'((i + 1) * 16));
        end
        for (int i = 0; i < 4; i++) request(i, 3'(i));
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_arb(rr_order[k], 24'((rr_order[k] + 1) << 20), 24'((rr_order[k] + 1) * 16));
            run_loader(rr_order[k], 1, 3, 1'b0,
                       24'((rr_order[k] + 1) << 20), 24'((rr_order[k] + 1) * 16));
            m_rr = (rr_order[k] + 1) % 4;
        end
        req_r = 4'd0;

        // Randomized traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            for (int r = 0; r < 4; r++) begin
                if (!req_r[r] && $urandom_range(1, 0) == 1) request(r, 3'($urandom_range(7, 0)));
            end
            if (req_r == 4'd0) request(it % 4, 3'($urandom_range(7, 0)));
            g  = model_pick(req_r);
            ea = m_addr[slot_r[g]];
            el = m_len[slot_r[g]];
            if ($urandom_range(2, 0) == 0) begin
                rl = ($urandom_range(3, 0) == 0) ? 24'd0 : 24'($urandom_range(24'hFFFFFF, 1));
                set_cfg(3'($urandom_range(7, 0)), 24'($urandom), rl);
            end
            tick();
            cfg_we = 1'b0;
            expect_arb(g, ea, el);
            if (el != 24'd0) begin
                run_loader(g, $urandom_range(4, 0), $urandom_range(15, 2),
                           ($urandom_range(3, 0) == 0), ea, el);
            end
            finish_txn(g);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
